// File: rtl/vlb_walk_arb.sv
// ---------------------------------------------------------------------------
// vlb_walk_arb
//
// Shares a single page-table memory port between N_REQ VLB miss requesters.
// Each port owns one slot that holds a pending miss (idx, vpn). Slots are
// served round-robin, one walk at a time. A walk fetches the 64 B line that
// holds the 64-bit PTE, decodes it and returns a fill pulse to the owning
// port. Any port can kill its pending or in-flight miss.
//
// Optional build macro:
//   VLB_WALK_ARB_BARE_EN - when defined, a grant made while satp_i[63:60]==0
//                          (bare mode) skips memory and returns an identity
//                          fill (mpn = vpn, vld=1, err=0, attr=4'hF).
//
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   req_i_valid/_bits_*      per-port miss request (idx, vpn), packed per port
//   kill_i                   per-port kill
//   busy_o                   per-port slot occupied
//   resp_o_valid             one-hot fill pulse
//   resp_o_bits_*            fill payload (zero while no pulse)
//   mem_req_o_*              line-address request channel (valid/ready)
//   mem_resp_i_*             line-data response channel (valid/ready)
//   satp_i                   [63:60] translation mode, [43:0] root PPN
// ---------------------------------------------------------------------------
module vlb_walk_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 4,
    parameter int VPN_W = 52,
    parameter int MPN_W = 52,
    parameter int MCN_W = 58
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_i_valid,
    input  logic [N_REQ*IDX_W-1:0]   req_i_bits_idx,
    input  logic [N_REQ*VPN_W-1:0]   req_i_bits_vpn,
    input  logic [N_REQ-1:0]         kill_i,
    output logic [N_REQ-1:0]         busy_o,
    output logic [N_REQ-1:0]         resp_o_valid,
    output logic [IDX_W-1:0]         resp_o_bits_idx,
    output logic                     resp_o_bits_vld,
    output logic                     resp_o_bits_err,
    output logic [MPN_W-1:0]         resp_o_bits_mpn,
    output logic [3:0]               resp_o_bits_attr,
    input  logic                     mem_req_o_ready,
    output logic                     mem_req_o_valid,
    output logic [MCN_W-1:0]         mem_req_o_bits_mcn,
    output logic                     mem_resp_i_ready,
    input  logic                     mem_resp_i_valid,
    input  logic [511:0]             mem_resp_i_bits_data,
    input  logic [63:0]              satp_i
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Slot storage
    logic [N_REQ-1:0] slot_valid_reg;
    logic [IDX_W-1:0] slot_idx_reg [N_REQ];
    logic [VPN_W-1:0] slot_vpn_reg [N_REQ];

    // Per-slot decode
    logic [N_REQ-1:0] slot_granted;
    logic [N_REQ-1:0] eligible;

    // Arbitration
    logic [GW-1:0]    rr_reg;
    logic [GW-1:0]    grant_reg;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    hi_pick;
    logic [GW-1:0]    lo_pick;
    logic             hi_found;
    logic             found;
    logic [GW-1:0]    rr_after;

    // Walk context
    logic             killed_reg;
    logic             bare_reg;
    logic [MCN_W-1:0] mcn_reg;
    logic [2:0]       wsel_reg;
    logic [63:0]      pte_reg;

    logic [VPN_W-1:0] pick_vpn;
    logic [VPN_W-1:0] grant_vpn;
    logic [IDX_W-1:0] grant_idx;
    logic [63:0]      mcn_sum;
    logic             bare_hit;
    logic             resp_fire;

    // Decoded fill payload before output gating
    logic             fill_vld;
    logic             fill_err;
    logic [3:0]       fill_attr;
    logic [MPN_W-1:0] fill_mpn;

    // -----------------------------------------------------------------------
    // Per-slot combinational decode
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
            // The granted slot is locked from IDLE-exit until the RESP cycle.
            assign slot_granted[gi] = (state_reg != S_IDLE) && (grant_reg == GW'(gi));
            // A slot killed in the same cycle must not win arbitration.
            assign eligible[gi]     = slot_valid_reg[gi] && !kill_i[gi];
            assign busy_o[gi]       = slot_valid_reg[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Slot registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_reg <= '0;
            for (int p = 0; p < N_REQ; p++) begin
                slot_idx_reg[p] <= '0;
                slot_vpn_reg[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_REQ; p++) begin
                if (slot_granted[p]) begin
                    // Locked while walking; kill only marks the walk (below),
                    // and new requests are dropped. Release at end of walk.
                    if (state_reg == S_RESP) begin
                        slot_valid_reg[p] <= 1'b0;
                    end
                end else if (req_i_valid[p] && (!slot_valid_reg[p] || kill_i[p])) begin
                    // Kill together with a request discards the old miss and
                    // keeps the new one.
                    slot_valid_reg[p] <= 1'b1;
                    slot_idx_reg[p]   <= req_i_bits_idx[p*IDX_W +: IDX_W];
                    slot_vpn_reg[p]   <= req_i_bits_vpn[p*VPN_W +: VPN_W];
                end else if (kill_i[p]) begin
                    slot_valid_reg[p] <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: lowest eligible index at or above rr, else lowest
    // eligible index overall (wrap-around). Descending loop so the last
    // assignment is the lowest index.
    // -----------------------------------------------------------------------
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        found    = 1'b0;
        lo_pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                if (GW'(i) >= rr_reg) begin
                    hi_found = 1'b1;
                    hi_pick  = GW'(i);
                end
                found   = 1'b1;
                lo_pick = GW'(i);
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    assign rr_after  = (int'(grant_reg) == N_REQ - 1) ? '0 : grant_reg + GW'(1);

    assign pick_vpn  = slot_vpn_reg[pick];
    assign grant_vpn = slot_vpn_reg[grant_reg];
    assign grant_idx = slot_idx_reg[grant_reg];

    // Line number of the PTE: root table base (in lines) plus vpn/8, since
    // eight 64-bit PTEs share one 64 B line.
    assign mcn_sum = {14'b0, satp_i[43:0], 6'b0} + 64'(pick_vpn >> 3);

`ifdef VLB_WALK_ARB_BARE_EN
    assign bare_hit = (satp_i[63:60] == 4'd0);
`else
    assign bare_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        mem_req_o_valid    = 1'b0;
        mem_req_o_bits_mcn = '0;
        mem_resp_i_ready   = 1'b0;
        resp_fire          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    state_next = bare_hit ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_o_valid    = 1'b1;
                mem_req_o_bits_mcn = mcn_reg;
                if (mem_req_o_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_resp_i_ready = 1'b1;
                if (mem_resp_i_valid) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_fire  = !killed_reg;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Walk context registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_reg     <= '0;
            grant_reg  <= '0;
            killed_reg <= 1'b0;
            bare_reg   <= 1'b0;
            mcn_reg    <= '0;
            wsel_reg   <= '0;
            pte_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (found) begin
                        grant_reg  <= pick;
                        mcn_reg    <= mcn_sum[MCN_W-1:0];
                        wsel_reg   <= pick_vpn[2:0];
                        bare_reg   <= bare_hit;
                        killed_reg <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (kill_i[grant_reg]) begin
                        killed_reg <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (kill_i[grant_reg]) begin
                        killed_reg <= 1'b1;
                    end
                    if (mem_resp_i_valid) begin
                        pte_reg <= mem_resp_i_bits_data[{wsel_reg, 6'b0} +: 64];
                    end
                end
                S_RESP: begin
                    killed_reg <= 1'b0;
                    rr_reg     <= rr_after;
                end
                default: begin
                    killed_reg <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Fill decode; a PTE marked valid but with no permission bits is flagged
    // as malformed.
    // -----------------------------------------------------------------------
    always_comb begin
        if (bare_reg) begin
            fill_vld  = 1'b1;
            fill_err  = 1'b0;
            fill_attr = 4'hF;
            fill_mpn  = MPN_W'(grant_vpn);
        end else begin
            fill_vld  = pte_reg[0];
            fill_attr = pte_reg[4:1];
            fill_err  = pte_reg[0] && (pte_reg[4:1] == 4'd0);
            fill_mpn  = pte_reg[10 +: MPN_W];
        end
    end

    assign resp_o_valid     = resp_fire ? (N_REQ'(1) << grant_reg) : '0;
    assign resp_o_bits_idx  = resp_fire ? grant_idx : '0;
    assign resp_o_bits_vld  = resp_fire && fill_vld;
    assign resp_o_bits_err  = resp_fire && fill_err;
    assign resp_o_bits_attr = resp_fire ? fill_attr : 4'd0;
    assign resp_o_bits_mpn  = resp_fire ? fill_mpn : '0;

    // Bits of the PTE, satp and address sum that the walk does not consume.
    logic unused_bits;
    assign unused_bits = ^{satp_i, mcn_sum, pte_reg};

endmodule

// File: tb/tb_vlb_walk_arb.sv
// ---------------------------------------------------------------------------
// tb_vlb_walk_arb
//
// Directed testbench for vlb_walk_arb: reset, single walk latency and decode,
// round-robin order, kill in flight, kill while pending, memory backpressure,
// malformed PTE, and (with VLB_WALK_ARB_BARE_EN) bare-mode fills.
// ---------------------------------------------------------------------------
module tb_vlb_walk_arb;

    localparam int N_REQ = 2;
    localparam int IDX_W = 4;
    localparam int VPN_W = 52;
    localparam int MPN_W = 52;
    localparam int MCN_W = 58;

    // Mode 8 keeps every walk on the memory path even in bare-enabled builds.
    localparam logic [63:0] SATP_WALK = 64'h8000_0000_0000_0100;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_i_valid;
    logic [N_REQ*IDX_W-1:0] req_i_bits_idx;
    logic [N_REQ*VPN_W-1:0] req_i_bits_vpn;
    logic [N_REQ-1:0]       kill_i;
    logic [N_REQ-1:0]       busy_o;
    logic [N_REQ-1:0]       resp_o_valid;
    logic [IDX_W-1:0]       resp_o_bits_idx;
    logic                   resp_o_bits_vld;
    logic                   resp_o_bits_err;
    logic [MPN_W-1:0]       resp_o_bits_mpn;
    logic [3:0]             resp_o_bits_attr;
    logic                   mem_req_o_ready;
    logic                   mem_req_o_valid;
    logic [MCN_W-1:0]       mem_req_o_bits_mcn;
    logic                   mem_resp_i_ready;
    logic                   mem_resp_i_valid;
    logic [511:0]           mem_resp_i_bits_data;
    logic [63:0]            satp_i;

    int checks = 0;
    int errors = 0;

    vlb_walk_arb #(
        .N_REQ(N_REQ), .IDX_W(IDX_W), .VPN_W(VPN_W), .MPN_W(MPN_W), .MCN_W(MCN_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .req_i_valid         (req_i_valid),
        .req_i_bits_idx      (req_i_bits_idx),
        .req_i_bits_vpn      (req_i_bits_vpn),
        .kill_i              (kill_i),
        .busy_o              (busy_o),
        .resp_o_valid        (resp_o_valid),
        .resp_o_bits_idx     (resp_o_bits_idx),
        .resp_o_bits_vld     (resp_o_bits_vld),
        .resp_o_bits_err     (resp_o_bits_err),
        .resp_o_bits_mpn     (resp_o_bits_mpn),
        .resp_o_bits_attr    (resp_o_bits_attr),
        .mem_req_o_ready     (mem_req_o_ready),
        .mem_req_o_valid     (mem_req_o_valid),
        .mem_req_o_bits_mcn  (mem_req_o_bits_mcn),
        .mem_resp_i_ready    (mem_resp_i_ready),
        .mem_resp_i_valid    (mem_resp_i_valid),
        .mem_resp_i_bits_data(mem_resp_i_bits_data),
        .satp_i              (satp_i)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_i_valid          = '0;
        kill_i               = '0;
        mem_resp_i_valid     = 1'b0;
        mem_resp_i_bits_data = '0;
    endtask

    task automatic set_req(input int p, input logic [IDX_W-1:0] idx, input logic [VPN_W-1:0] vpn);
        req_i_valid[p]                   = 1'b1;
        req_i_bits_idx[p*IDX_W +: IDX_W] = idx;
        req_i_bits_vpn[p*VPN_W +: VPN_W] = vpn;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        clear_inputs();
        req_i_bits_idx  = '0;
        req_i_bits_vpn  = '0;
        mem_req_o_ready = 1'b1;
        satp_i          = SATP_WALK;
        step();
        step();
        reset = 1'b0;
    endtask

    // Waits for the memory request, answers it with a line whose word wsel
    // holds pte (other words are decoys), and checks the resulting fill.
    // Returns in the RESP cycle. waited = cycles spent before the request.
    task automatic run_walk(
        input  logic [63:0]      pte,
        input  logic [2:0]       wsel,
        input  logic [MCN_W-1:0] exp_mcn,
        input  logic [N_REQ-1:0] exp_valid,
        input  logic [IDX_W-1:0] exp_idx,
        input  logic             exp_vld,
        input  logic             exp_err,
        input  logic [3:0]       exp_attr,
        input  logic [MPN_W-1:0] exp_mpn,
        input  string            name,
        output int               waited
    );
        logic [511:0] line;
        mem_req_o_ready = 1'b1;
        waited = 0;
        while (mem_req_o_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (mem_req_o_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout: mem_req_o_valid=%b required 1", name, mem_req_o_valid);
            return;
        end
        checks++;
        if (mem_req_o_bits_mcn !== exp_mcn) begin
            errors++;
            $display("FAIL %s mcn: got %h required %h", name, mem_req_o_bits_mcn, exp_mcn);
        end
        step();
        checks++;
        if (mem_resp_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s resp_ready: got %b required 1", name, mem_resp_i_ready);
        end
        for (int k = 0; k < 8; k++) begin
            line[64*k +: 64] = (k == int'(wsel)) ? pte : (64'hFFFF_FFFF_FFFF_FF00 | 64'(k));
        end
        mem_resp_i_valid     = 1'b1;
        mem_resp_i_bits_data = line;
        step();
        mem_resp_i_valid     = 1'b0;
        mem_resp_i_bits_data = '0;
        checks++;
        if (resp_o_valid !== exp_valid || resp_o_bits_idx !== exp_idx) begin
            errors++;
            $display("FAIL %s fill_port: valid=%b idx=%0d required valid=%b idx=%0d",
                     name, resp_o_valid, resp_o_bits_idx, exp_valid, exp_idx);
        end
        checks++;
        if (resp_o_bits_vld !== exp_vld || resp_o_bits_err !== exp_err ||
            resp_o_bits_attr !== exp_attr || resp_o_bits_mpn !== exp_mpn) begin
            errors++;
            $display("FAIL %s fill_data: vld=%b err=%b attr=%h mpn=%h required vld=%b err=%b attr=%h mpn=%h",
                     name, resp_o_bits_vld, resp_o_bits_err, resp_o_bits_attr, resp_o_bits_mpn,
                     exp_vld, exp_err, exp_attr, exp_mpn);
        end
        $display("walk %s: mcn=%h valid=%b idx=%0d vld=%b err=%b attr=%h mpn=%h", name,
                 exp_mcn, resp_o_valid, resp_o_bits_idx, resp_o_bits_vld, resp_o_bits_err,
                 resp_o_bits_attr, resp_o_bits_mpn);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy_o !== 2'b00 || resp_o_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_resp: busy=%b resp=%b required 00 00", busy_o, resp_o_valid);
        end
        checks++;
        if (mem_req_o_valid !== 1'b0 || mem_req_o_bits_mcn !== '0 || mem_resp_i_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: req_valid=%b mcn=%h resp_ready=%b required 0 0 0",
                     mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready);
        end
        checks++;
        if (resp_o_bits_idx !== '0 || resp_o_bits_mpn !== '0 || resp_o_bits_attr !== 4'd0 ||
            resp_o_bits_vld !== 1'b0 || resp_o_bits_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_bits: idx=%h mpn=%h attr=%h vld=%b err=%b required all 0",
                     resp_o_bits_idx, resp_o_bits_mpn, resp_o_bits_attr, resp_o_bits_vld, resp_o_bits_err);
        end
        $display("reset: busy=%b resp=%b req_valid=%b", busy_o, resp_o_valid, mem_req_o_valid);
    endtask

    task automatic test_reset_mid_walk();
        bit seen;
        do_reset();
        mem_req_o_ready = 1'b0;
        set_req(0, 4'd6, 52'h13);
        step();
        clear_inputs();
        step();
        checks++;
        if (mem_req_o_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: mem_req_o_valid=%b required 1", mem_req_o_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy_o !== 2'b00 || mem_req_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_post: busy=%b req_valid=%b required 00 0", busy_o, mem_req_o_valid);
        end
        mem_req_o_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (mem_req_o_valid === 1'b1 || resp_o_valid !== 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_idle: activity seen=%b required 0", seen);
        end
        $display("reset mid-walk: busy=%b", busy_o);
    endtask

    task automatic test_single_walk();
        int waited;
        do_reset();
        set_req(0, 4'd3, 52'h13);
        step();
        clear_inputs();
        checks++;
        if (busy_o !== 2'b01 || mem_req_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: busy=%b req_valid=%b required 01 0", busy_o, mem_req_o_valid);
        end
        run_walk(64'h0000_0000_0004_2C03, 3'd3, 58'h4002, 2'b01, 4'd3,
                 1'b1, 1'b0, 4'd1, 52'h10B, "single", waited);
        // Request at cycle 2 means fill at cycle 4.
        checks++;
        if (waited != 1) begin
            errors++;
            $display("FAIL single_latency: request after %0d cycles required 1", waited);
        end
        step();
        checks++;
        if (busy_o !== 2'b00 || resp_o_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_after: busy=%b resp=%b required 00 00", busy_o, resp_o_valid);
        end
    endtask

    task automatic test_round_robin();
        int waited;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            set_req(0, 4'd1, 52'h8);
            set_req(1, 4'd2, 52'h11);
            step();
            clear_inputs();
            run_walk(64'h0000_0000_0000_0403, 3'd0, 58'h4001, 2'b01, 4'd1,
                     1'b1, 1'b0, 4'd1, 52'h1, "rr_first_p0", waited);
            run_walk(64'h0000_0000_0000_0805, 3'd1, 58'h4002, 2'b10, 4'd2,
                     1'b1, 1'b0, 4'd2, 52'h2, "rr_second_p1", waited);
            step();
        end
        // Serve port 0 alone so the pointer moves to 1, then collide again.
        set_req(0, 4'd1, 52'h8);
        step();
        clear_inputs();
        run_walk(64'h0000_0000_0000_0403, 3'd0, 58'h4001, 2'b01, 4'd1,
                 1'b1, 1'b0, 4'd1, 52'h1, "rr_solo_p0", waited);
        step();
        set_req(0, 4'd1, 52'h8);
        set_req(1, 4'd2, 52'h11);
        step();
        clear_inputs();
        run_walk(64'h0000_0000_0000_0805, 3'd1, 58'h4002, 2'b10, 4'd2,
                 1'b1, 1'b0, 4'd2, 52'h2, "rr_wrap_p1", waited);
        run_walk(64'h0000_0000_0000_0403, 3'd0, 58'h4001, 2'b01, 4'd1,
                 1'b1, 1'b0, 4'd1, 52'h1, "rr_wrap_p0", waited);
        step();
    endtask

    task automatic test_kill_in_flight();
        do_reset();
        set_req(1, 4'd5, 52'h8);
        step();
        clear_inputs();
        step();
        checks++;
        if (mem_req_o_valid !== 1'b1 || mem_req_o_bits_mcn !== 58'h4001) begin
            errors++;
            $display("FAIL kill_flight_req: valid=%b mcn=%h required 1 4001", mem_req_o_valid, mem_req_o_bits_mcn);
        end
        step();
        checks++;
        if (mem_resp_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_flight_wait: resp_ready=%b required 1", mem_resp_i_ready);
        end
        kill_i                       = 2'b10;
        mem_resp_i_valid             = 1'b1;
        mem_resp_i_bits_data[63:0]   = 64'h0000_0000_0000_0403;
        step();
        clear_inputs();
        checks++;
        if (resp_o_valid !== 2'b00 || resp_o_bits_idx !== 4'd0 || busy_o !== 2'b10) begin
            errors++;
            $display("FAIL kill_flight_resp: resp=%b idx=%0d busy=%b required 00 0 10",
                     resp_o_valid, resp_o_bits_idx, busy_o);
        end
        step();
        checks++;
        if (busy_o !== 2'b00 || resp_o_valid !== 2'b00) begin
            errors++;
            $display("FAIL kill_flight_after: busy=%b resp=%b required 00 00", busy_o, resp_o_valid);
        end
        $display("kill in flight: busy=%b resp=%b", busy_o, resp_o_valid);
    endtask

    task automatic test_kill_pending();
        int waited;
        bit seen;
        do_reset();
        set_req(0, 4'd1, 52'h8);
        set_req(1, 4'd2, 52'h10);
        step();
        clear_inputs();
        checks++;
        if (busy_o !== 2'b11) begin
            errors++;
            $display("FAIL kill_pend_busy: busy=%b required 11", busy_o);
        end
        kill_i = 2'b10;
        step();
        kill_i = 2'b00;
        checks++;
        if (busy_o !== 2'b01) begin
            errors++;
            $display("FAIL kill_pend_clear: busy=%b required 01", busy_o);
        end
        run_walk(64'h0000_0000_0000_0403, 3'd0, 58'h4001, 2'b01, 4'd1,
                 1'b1, 1'b0, 4'd1, 52'h1, "kill_pend_p0", waited);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (mem_req_o_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || busy_o !== 2'b00) begin
            errors++;
            $display("FAIL kill_pend_noreq: req_seen=%b busy=%b required 0 00", seen, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        do_reset();
        mem_req_o_ready = 1'b0;
        set_req(0, 4'd2, 52'h13);
        step();
        clear_inputs();
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (mem_req_o_valid !== 1'b1 || mem_req_o_bits_mcn !== 58'h4002) begin
                errors++;
                $display("FAIL backpressure_hold%0d: valid=%b mcn=%h required 1 4002",
                         c, mem_req_o_valid, mem_req_o_bits_mcn);
            end
            if (c == 0) set_req(0, 4'd7, 52'h8);
            step();
            clear_inputs();
        end
        checks++;
        if (busy_o !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_busy: busy=%b required 01", busy_o);
        end
        run_walk(64'h0000_0000_0004_2C03, 3'd3, 58'h4002, 2'b01, 4'd2,
                 1'b1, 1'b0, 4'd1, 52'h10B, "backpressure", waited);
        step();
        checks++;
        if (busy_o !== 2'b00) begin
            errors++;
            $display("FAIL backpressure_dup: busy=%b required 00 (duplicate dropped)", busy_o);
        end
    endtask

    task automatic test_malformed();
        int waited;
        do_reset();
        set_req(1, 4'd9, 52'h0);
        step();
        clear_inputs();
        run_walk(64'h0000_0000_0000_0001, 3'd0, 58'h4000, 2'b10, 4'd9,
                 1'b1, 1'b1, 4'd0, 52'h0, "malformed", waited);
        step();
    endtask

`ifdef VLB_WALK_ARB_BARE_EN
    task automatic test_bare();
        do_reset();
        satp_i = 64'h0000_0000_0000_0100;
        set_req(0, 4'd4, 52'h55);
        step();
        clear_inputs();
        checks++;
        if (mem_req_o_valid !== 1'b0 || resp_o_valid !== 2'b00) begin
            errors++;
            $display("FAIL bare_c1: req_valid=%b resp=%b required 0 00", mem_req_o_valid, resp_o_valid);
        end
        step();
        checks++;
        if (resp_o_valid !== 2'b01 || resp_o_bits_idx !== 4'd4 || resp_o_bits_mpn !== 52'h55 ||
            resp_o_bits_attr !== 4'hF || resp_o_bits_vld !== 1'b1 || resp_o_bits_err !== 1'b0 ||
            mem_req_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bare_fill: valid=%b idx=%0d mpn=%h attr=%h vld=%b err=%b req=%b required 01 4 55 f 1 0 0",
                     resp_o_valid, resp_o_bits_idx, resp_o_bits_mpn, resp_o_bits_attr,
                     resp_o_bits_vld, resp_o_bits_err, mem_req_o_valid);
        end
        $display("bare: valid=%b mpn=%h attr=%h", resp_o_valid, resp_o_bits_mpn, resp_o_bits_attr);
        step();
        satp_i = SATP_WALK;
    endtask
`endif

    initial begin
        reset                = 1'b1;
        req_i_valid          = '0;
        req_i_bits_idx       = '0;
        req_i_bits_vpn       = '0;
        kill_i               = '0;
        mem_req_o_ready      = 1'b1;
        mem_resp_i_valid     = 1'b0;
        mem_resp_i_bits_data = '0;
        satp_i               = SATP_WALK;

        test_reset();
        test_reset_mid_walk();
        test_single_walk();
        test_round_robin();
        test_kill_in_flight();
        test_kill_pending();
        test_backpressure();
        test_malformed();
`ifdef VLB_WALK_ARB_BARE_EN
        test_bare();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vlb_walk_arb.md
Name: vlb_walk_arb

Overview:
- Shares one page-table memory port between N_REQ VLB miss requesters.
- Per port: one slot holding a miss (idx, vpn). Slots are arbitrated round-robin, one walk at a time.
- Each walk fetches the 64 B line holding the 64-bit PTE, decodes it, and returns a fill to the owning port.
- Sits between the VLB miss logic and the walker memory channel; supports per-port kill.

Parameters:
- N_REQ, 2: number of requester ports (2..8).
- IDX_W, 4: VLB entry index width.
- VPN_W, 52: virtual page number width.
- MPN_W, 52: physical page number width.
- MCN_W, 58: cache line number width.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_i_valid  in  N_REQ  per-port miss request pulse.
- req_i_bits_idx  in  N_REQ*IDX_W  per-port VLB index.
- req_i_bits_vpn  in  N_REQ*VPN_W  per-port VPN.
- kill_i  in  N_REQ  per-port kill.
- busy_o  out  N_REQ  slot occupied.
- resp_o_valid  out  N_REQ  one-hot fill pulse.
- resp_o_bits_idx  out  IDX_W  fill index.
- resp_o_bits_vld  out  1  PTE valid.
- resp_o_bits_err  out  1  PTE malformed.
- resp_o_bits_mpn  out  MPN_W  physical page number.
- resp_o_bits_attr  out  4  attributes.
- mem_req_o_ready  in  1  memory accepts request.
- mem_req_o_valid  out  1  request valid.
- mem_req_o_bits_mcn  out  MCN_W  line address.
- mem_resp_i_ready  out  1  ready for response.
- mem_resp_i_valid  in  1  response valid.
- mem_resp_i_bits_data  in  512  line data.
- satp_i  in  64  [63:60] mode, [43:0] root PPN.

Behaviour:
- Reset: all outputs 0, all slots empty, state IDLE, rr pointer 0.
- Slot fill:
  - req_i_valid[p] sets slot p (valid, idx, vpn) on the next cycle.
  - A request to an occupied slot is ignored. Requesters must hold at most one outstanding miss; busy_o[p] = slot p valid.
- Kill:
  - kill_i[p] clears slot p if it is not granted.
  - If slot p is granted, kill sets killed_q. The walk completes, no resp_o pulse is produced, and the slot clears at the end of the walk.
  - req_i_valid[p] together with kill_i[p] in the same cycle: kill applies to the old content and the new request is accepted. When slot p is granted, the new request is ignored (busy_o stays 1).
- FSM:
  - IDLE: if any valid slot exists, grant the first valid slot at or after the rr pointer and go to REQ. A slot killed in this same cycle is not eligible.
  - REQ: mem_req_o_valid=1. mcn = ({satp_i[43:0],6'b0} + vpn[VPN_W-1:3]) truncated to MCN_W. mcn is held stable until mem_req_o_ready, then go to WAIT. Kill does not withdraw the request.
  - WAIT: mem_resp_i_ready=1. On mem_resp_i_valid, capture pte = data[64*vpn[2:0] +: 64] and go to RESP.
  - RESP, one cycle:
    - If not killed, pulse resp_o_valid[grant]=1 with idx = slot idx, vld = pte[0], attr = pte[4:1], mpn = pte[10 +: MPN_W], err = pte[0] & (pte[4:1]==0).
    - Clear the slot and killed_q, set rr = grant+1 modulo N_REQ, go to IDLE.
- Bits fields are 0 when resp_o_valid is 0.
- Minimum latency: req at cycle 0 → grant at 1 → mem_req_o_valid at 2 (ready same cycle) → resp at 3 → resp_o_valid at 4.
- A given port is re-granted only after every other pending port has been served.
- Reset mid-walk: return to IDLE and empty all slots. The memory side is reset together with this block, so no stale response arrives.

Optional Feature:
- Macro VLB_WALK_ARB_BARE_EN.
- When defined, and satp_i[63:60]==0 (bare mode) at grant time:
  - Skip REQ and WAIT; go IDLE→RESP directly.
  - Fill values: vld=1, err=0, attr=4'hF, mpn = vpn zero-extended or truncated to MPN_W.
- When not defined: satp mode is ignored and every request walks memory.

Test Plan:
- Single walk: satp PPN=0x100, port0 vpn=0x13, idx=3, mem_req_o_ready=1, resp data word3 = 0x0000_0000_0004_2C03 → mcn=0x4002, resp_o_valid=2'b01 at cycle 4, idx=3, vld=1, attr=1, mpn=0x10B, err=0.
- Round-robin: ports 0 and 1 request in the same cycle, rr=0 → port0 served first, then port1. Repeated simultaneous requests alternate 0,1,0,1.
- Kill in flight: kill_i[1] while port1 is in WAIT → mem handshake completes, no resp_o_valid, busy_o[1] falls in the cycle after RESP.
- Kill pending: port0 granted, port1 pending, kill_i[1] → busy_o[1]=0 next cycle, and no memory request is issued for port1.
- Backpressure: mem_req_o_ready low for 5 cycles → mem_req_o_valid and mcn stay stable for all 5; a duplicate req on the busy port is ignored.
- Malformed PTE: PTE=0x1 → vld=1, err=1. With VLB_WALK_ARB_BARE_EN and satp mode 0, vpn=0x55 → no mem_req_o_valid, fill mpn=0x55, attr=0xF, 2 cycles after the request.
